multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter: CNT_WIDTH, 32, width of retired-instruction counter.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: opcode  input  7  instr[6:0] from instruction register.
REQ-005 SHALL have port: funct3  input  3  instr[14:12].
REQ-006 SHALL have port: alu_zero  input  1  ALU zero flag (valid in BRANCH).
REQ-007 SHALL have port: mem_ready  input  1  memory handshake completion.
REQ-008 SHALL have ports: mem_req / mem_we  output  1 each  memory request, write enable.
REQ-009 SHALL have ports: ir_write / pc_write / reg_write  output  1 each  register update strobes.
REQ-010 SHALL have port: imm_sel  output  2  extender select: 0 I, 1 S, 2 SB, 3 U.
REQ-011 SHALL have port: alu_op  output  2  0 ADD, 1 SUB, 2 FUNCT-decoded, 3 PASS-B.
REQ-012 SHALL have ports: alu_src_a  output  1 (0 PC, 1 rs1); alu_src_b  output  2 (0 rs2, 1 imm, 2 const 4).
REQ-013 SHALL have ports: wb_sel  output  1 (0 ALU, 1 mem data); branch_taken  output  1  pulse.
REQ-014 SHALL have ports: retire  output  1  pulse; retire_count  output  CNT_WIDTH; illegal  output  1  sticky.

Function
REQ-015 SHALL implement states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WR, EXEC_R, EXEC_I, WB_ALU, WB_MEM, BRANCH, LUI, TRAP.
REQ-016 FETCH SHALL assert mem_req=1, mem_we=0, alu_src_a=0, alu_src_b=2, alu_op=ADD; hold until mem_ready; on mem_ready pulse ir_write and pc_write, go DECODE.
REQ-017 DECODE SHALL register imm_sel from opcode: 0000011/0010011->0, 0100011->1, 1100011->2, 0110111->3; imm_sel SHALL hold until next DECODE.
REQ-018 DECODE SHALL branch: 0000011/0100011->MEM_ADDR, 0110011->EXEC_R, 0010011->EXEC_I, 1100011->BRANCH, 0110111->LUI, other->TRAP.
REQ-019 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=1, ADD; go MEM_RD if opcode=0000011, else MEM_WR.
REQ-020 MEM_RD/MEM_WR SHALL hold mem_req=1 (mem_we=1 in MEM_WR) until mem_ready; mem_req never drops mid-handshake; then MEM_RD->WB_MEM, MEM_WR->FETCH with retire.
REQ-021 EXEC_R: src_a=1, src_b=0, FUNCT; EXEC_I: src_a=1, src_b=1, FUNCT; both ->WB_ALU.
REQ-022 WB_ALU (wb_sel=0) and WB_MEM (wb_sel=1) SHALL pulse reg_write one cycle, pulse retire, go FETCH.
REQ-023 BRANCH: src_a=1, src_b=0, SUB; branch_taken=alu_zero when funct3=000, else 0; pulse retire; go FETCH.
REQ-024 LUI: alu_op=PASS-B, src_b=1, pulse reg_write (wb_sel=0) and retire, go FETCH.
REQ-025 TRAP SHALL set illegal=1, drive all strobes/requests 0, remain until reset.
REQ-026 Latency with mem_ready tied high, FETCH to next FETCH: R/I 4, lw 5, sw 4, beq 3, lui 3 cycles.
REQ-027 retire_count SHALL increment by 1 per retire pulse, wrapping from all-ones to 0.
REQ-028 All strobes not listed for a state SHALL be 0; outputs SHALL be Moore (state-decoded) except branch_taken.

Reset
REQ-029 Reset SHALL force FETCH next cycle, imm_sel=0, retire_count=0, illegal=0.
REQ-030 While reset high, all outputs SHALL be 0; an outstanding mem_req SHALL be abandoned, with reset taking priority over mem_ready in the same cycle.

Structure
REQ-031 SHALL place state enum, imm_sel codes (I/S/SB/U), alu_op codes and opcode constants in shared package riscv_ctrl_pkg.
REQ-032 SHALL use one sub-module, opcode_decoder, a combinational map from opcode to {imm_sel, next-state class, legal}.

Verification
REQ-033 addi (0010011), mem_ready=1 -> imm_sel=0, reg_write pulse at cycle 4, retire_count 0->1.
REQ-034 sw (0100011), mem_ready delayed 3 cycles in MEM_WR -> mem_req=1, mem_we=1 held 4 cycles, imm_sel=1, no reg_write.
REQ-035 beq with alu_zero=1 -> imm_sel=2, branch_taken=1 in cycle 3; with alu_zero=0 -> branch_taken=0.
REQ-036 opcode 1111111 -> TRAP, illegal=1 stays set across 10 cycles until reset, retire_count unchanged.
REQ-037 reset asserted in MEM_RD while mem_req=1 and mem_ready=1 -> next cycle FETCH, mem_req=0, retire_count=0.
REQ-038 retire_count preset to 32'hFFFFFFFF by running lui stream -> next retire wraps to 0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control FSM: states, datapath
// select codes, opcodes and the decoder's result record.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_EXEC_R,
        S_EXEC_I, S_WB_ALU, S_WB_MEM, S_BRANCH, S_LUI, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_MEM, CLS_R, CLS_I, CLS_BR, CLS_LUI, CLS_ILL
    } op_class_t;

    localparam logic [1:0] IMM_I  = 2'd0;
    localparam logic [1:0] IMM_S  = 2'd1;
    localparam logic [1:0] IMM_SB = 2'd2;
    localparam logic [1:0] IMM_U  = 2'd3;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_PASSB = 2'd3;

    localparam logic       SRC_A_PC   = 1'b0;
    localparam logic       SRC_A_RS1  = 1'b1;
    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef struct packed {
        logic [1:0] imm_sel;
        op_class_t  cls;
        logic       legal;
    } dec_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode map to immediate format, instruction class and legality.
module opcode_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec = '{imm_sel: IMM_I, cls: CLS_ILL, legal: 1'b0};
        case (opcode)
            OP_LOAD:   dec = '{imm_sel: IMM_I,  cls: CLS_MEM, legal: 1'b1};
            OP_STORE:  dec = '{imm_sel: IMM_S,  cls: CLS_MEM, legal: 1'b1};
            OP_RTYPE:  dec = '{imm_sel: IMM_I,  cls: CLS_R,   legal: 1'b1};
            OP_ITYPE:  dec = '{imm_sel: IMM_I,  cls: CLS_I,   legal: 1'b1};
            OP_BRANCH: dec = '{imm_sel: IMM_SB, cls: CLS_BR,  legal: 1'b1};
            OP_LUI:    dec = '{imm_sel: IMM_U,  cls: CLS_LUI, legal: 1'b1};
            default:   dec = '{imm_sel: IMM_I,  cls: CLS_ILL, legal: 1'b0};
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: Moore strobes per state, registered imm_sel,
// retired-instruction counter and sticky illegal flag; reset blanks all outputs.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 alu_zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           imm_sel,
    output logic [1:0]           alu_op,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic                 wb_sel,
    output logic                 branch_taken,
    output logic                 retire,
    output logic [CNT_WIDTH-1:0] retire_count,
    output logic                 illegal
);

    state_t               state_q, state_d;
    dec_t                 dec;
    logic [1:0]           imm_sel_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 illegal_q;

    opcode_decoder u_dec (
        .opcode (opcode),
        .dec    (dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            imm_sel_q <= IMM_I;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                imm_sel_q <= dec.imm_sel;
                if (!dec.legal) illegal_q <= 1'b1;
            end
            if (retire) count_q <= count_q + 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        alu_op       = ALU_ADD;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_RS2;
        wb_sel       = 1'b0;
        branch_taken = 1'b0;
        retire       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                case (dec.cls)
                    CLS_MEM: state_d = S_MEM_ADDR;
                    CLS_R:   state_d = S_EXEC_R;
                    CLS_I:   state_d = S_EXEC_I;
                    CLS_BR:  state_d = S_BRANCH;
                    CLS_LUI: state_d = S_LUI;
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                state_d   = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                if (mem_ready) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALU_FUNCT;
                state_d   = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_FUNCT;
                state_d   = S_WB_ALU;
            end
            S_WB_ALU, S_WB_MEM: begin
                wb_sel    = (state_q == S_WB_MEM);
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = SRC_A_RS1;
                alu_op       = ALU_SUB;
                // Only BEQ is resolved here; other branch kinds fall through.
                branch_taken = alu_zero && (funct3 == 3'b000);
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_LUI: begin
                alu_op    = ALU_PASSB;
                alu_src_b = SRC_B_IMM;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_TRAP;
        endcase
        // Reset overrides everything, including an in-flight memory handshake.
        if (reset) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            ir_write     = 1'b0;
            pc_write     = 1'b0;
            reg_write    = 1'b0;
            alu_op       = ALU_ADD;
            alu_src_a    = SRC_A_PC;
            alu_src_b    = SRC_B_RS2;
            wb_sel       = 1'b0;
            branch_taken = 1'b0;
            retire       = 1'b0;
        end
    end

    assign imm_sel      = reset ? IMM_I : imm_sel_q;
    assign retire_count = reset ? '0 : count_q;
    assign illegal      = reset ? 1'b0 : illegal_q;

endmodule
